tile_map_arbiter: RTL
=====================

Name: tile_map_arbiter

Overview:
- Sequences and shares the single-ported level tile map between two requesters: the VGA tile renderer (read-only, pixel-timed) and the game-logic unit (read, collect-coin and bump-question-block operations).
- Performs read-modify-write atomically for game ops, so coins vanish and question blocks become used without races.
- Sits between the renderer/game FSM and the tile map memory, which has a 1-cycle read latency.
- Tile codes: AIR=4'h0, QUESTION=4'h1, COIN=4'h2, USED=4'h3.

Parameters:
- MAP_COLS, 211, tile columns per row (844-bit row / 4).
- MAP_ROWS, 13, tile rows (y 0..12).
- X_W, 8, column index width.
- Y_W, 4, row index width.
- TILE_W, 4, tile code width.
- STARVE_MAX, 8, maximum consecutive cycles the game port may lose arbitration before it is forced a grant.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irender_req  in  1  renderer read request, single cycle per lookup
- irender_x  in  X_W  renderer column
- irender_y  in  Y_W  renderer row
- orender_valid  out  1  renderer data valid pulse
- orender_tile  out  TILE_W  renderer tile code
- igame_req  in  1  game op request
- igame_op  in  2  00=READ, 01=COLLECT, 10=BUMP, 11=READ
- igame_x  in  X_W  game column
- igame_y  in  Y_W  game row
- ogame_busy  out  1  game op in progress
- ogame_ack  out  1  one-cycle completion pulse
- ogame_tile  out  TILE_W  tile value before any write
- ogame_hit  out  1  with ack: a write was performed
- omap_x  out  X_W  map address column
- omap_y  out  Y_W  map address row
- omap_rd  out  1  map read strobe; imap_rdata valid next cycle
- imap_rdata  in  TILE_W  map read data
- omap_we  out  1  map write strobe
- omap_wdata  out  TILE_W  map write data

Behaviour:
- Reset: all outputs 0, FSM in G_IDLE, starve counter 0; effective immediately (async). Reset mid-op abandons the op and issues no write.
- One map access per cycle: at most one of omap_rd / omap_we high.
- Arbitration per cycle: the game wins if it is requesting the port (G_RD or G_WR) and either irender_req=0 or starve==STARVE_MAX. Otherwise the renderer wins.
- Starve counter: increments, saturating, on each cycle the game requests and loses; clears on game grant. Maximum game wait is STARVE_MAX cycles.
- Render path:
  - Granted in-range request at cycle T: omap_rd=1 at T.
  - At T+2: orender_valid=1 and orender_tile=imap_rdata (registered from T+1).
  - Out-of-range request (x>=MAP_COLS or y>=MAP_ROWS): no map access, orender_valid at T+2 with AIR, and the slot goes to the game.
  - Losing request: dropped; no orender_valid for it. The renderer retries.
- Game FSM:
  - G_IDLE: when igame_req=1, latch op/x/y, set busy, go to G_RD. Requests while busy are ignored.
  - G_RD: if the latched coordinates are out of range, go to G_ACK with tile AIR and hit 0. Otherwise, on grant, omap_rd=1 and go to G_DATA.
  - G_DATA: capture imap_rdata into ogame_tile register, then:
    - COLLECT and tile==COIN: wdata=AIR, go to G_WR.
    - BUMP and tile==QUESTION: wdata=USED, go to G_WR.
    - Otherwise: go to G_ACK with hit 0.
  - G_WR: on grant, omap_we=1 at the latched address, set hit, go to G_ACK.
  - G_ACK: ogame_ack=1 for one cycle, busy cleared, return to G_IDLE. ogame_tile and ogame_hit hold until the next ack.
- Latency:
  - Uncontended READ: accept at T, rd T+1, data T+2, ack T+3.
  - Write op: ack at T+4.
- Ordering: render reads between a game read and its write return the old value. Render reads after the omap_we cycle return the new value. No other writer exists, so game RMW is atomic.
- Address mux: omap_x/omap_y follow the winner; they hold their last value when idle.

Test Plan:
- Reset mid-op: assert rst_n=0 during G_WR -> omap_we never pulses, all outputs 0, busy=0 after release.
- Render only: req at (5,3) with map data 4'h2 -> omap_rd same cycle, orender_valid with tile 2 two cycles later; back-to-back requests produce back-to-back valids.
- Game COLLECT on coin at (14,6), renderer idle -> rd, then we with wdata 0, ack with tile 2 and hit 1 four cycles after accept. Repeat the same op -> tile 0, hit 0, no write.
- Game BUMP on question at (14,7) -> write 4'h3, hit 1. BUMP on air -> no write.
- Starvation: irender_req held high continuously, game READ issued -> game granted exactly after 8 lost cycles; exactly one render request dropped that cycle.
- Out-of-range: game READ at (211,0) and render at (0,13) -> no map strobes; AIR returned; game ack 2 cycles after accept.

Source files
------------

// File: rtl/tile_map_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tile_map_arbiter
//  Description : Shares the single-ported level tile map between the VGA tile
//                renderer (read-only lookups) and the game-logic unit (read,
//                collect-coin and bump-question-block operations). Game
//                operations are performed as atomic read-modify-write, and the
//                game port is guaranteed a grant after STARVE_MAX lost cycles.
//  Ports       :
//    clk, rst_n                     clock, asynchronous active-low reset
//    irender_req/_x/_y              renderer lookup request (one cycle each)
//    orender_valid/_tile            renderer result, two cycles after grant
//    igame_req/_op/_x/_y            game op request (accepted when idle)
//    ogame_busy/_ack/_tile/_hit     game op status and result
//    omap_x/_y/_rd/_we/_wdata       tile map address and strobes
//    imap_rdata                     tile map read data (1-cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module tile_map_arbiter #(
    parameter int MAP_COLS   = 211,
    parameter int MAP_ROWS   = 13,
    parameter int X_W        = 8,
    parameter int Y_W        = 4,
    parameter int TILE_W     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irender_req,
    input  logic [X_W-1:0]    irender_x,
    input  logic [Y_W-1:0]    irender_y,
    output logic              orender_valid,
    output logic [TILE_W-1:0] orender_tile,
    input  logic              igame_req,
    input  logic [1:0]        igame_op,
    input  logic [X_W-1:0]    igame_x,
    input  logic [Y_W-1:0]    igame_y,
    output logic              ogame_busy,
    output logic              ogame_ack,
    output logic [TILE_W-1:0] ogame_tile,
    output logic              ogame_hit,
    output logic [X_W-1:0]    omap_x,
    output logic [Y_W-1:0]    omap_y,
    output logic              omap_rd,
    input  logic [TILE_W-1:0] imap_rdata,
    output logic              omap_we,
    output logic [TILE_W-1:0] omap_wdata
);

    localparam logic [X_W-1:0]    COLS_LIM   = X_W'(MAP_COLS);
    localparam logic [Y_W-1:0]    ROWS_LIM   = Y_W'(MAP_ROWS);
    localparam int                SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);

    localparam logic [TILE_W-1:0] TILE_AIR      = TILE_W'(0);
    localparam logic [TILE_W-1:0] TILE_QUESTION = TILE_W'(1);
    localparam logic [TILE_W-1:0] TILE_COIN     = TILE_W'(2);
    localparam logic [TILE_W-1:0] TILE_USED     = TILE_W'(3);

    localparam logic [1:0] OP_COLLECT = 2'b01;
    localparam logic [1:0] OP_BUMP    = 2'b10;

    localparam logic [2:0] G_IDLE = 3'd0;
    localparam logic [2:0] G_RD   = 3'd1;
    localparam logic [2:0] G_DATA = 3'd2;
    localparam logic [2:0] G_WR   = 3'd3;
    localparam logic [2:0] G_ACK  = 3'd4;

    logic [2:0]        state;
    logic [1:0]        op_q;
    logic [X_W-1:0]    gx;
    logic [Y_W-1:0]    gy;
    logic [SC_W-1:0]   starve;
    logic [X_W-1:0]    hold_x;
    logic [Y_W-1:0]    hold_y;
    logic [TILE_W-1:0] wdata_q;
    logic [TILE_W-1:0] tile_q;
    logic              hit_q;
    logic              rpipe_valid;   // render lookup in flight (map read cycle)
    logic              rpipe_air;     // in-flight lookup was out of range

    logic render_in_range;
    logic game_in_range;
    logic game_port_req;
    logic game_grant;
    logic render_grant;

    always_comb begin
        render_in_range = (irender_x < COLS_LIM) && (irender_y < ROWS_LIM);
        game_in_range   = (gx < COLS_LIM) && (gy < ROWS_LIM);
        // An out-of-range game read needs no map access, so it never competes.
        game_port_req   = ((state == G_RD) && game_in_range) || (state == G_WR);
        // An out-of-range render request frees the slot for the game.
        game_grant      = game_port_req &&
                          (!irender_req || !render_in_range || (starve == STARVE_LIM));
        render_grant    = irender_req && render_in_range && !game_grant;
    end

    assign omap_rd    = render_grant || (game_grant && (state == G_RD));
    assign omap_we    = game_grant && (state == G_WR);
    assign omap_x     = game_grant ? gx : (render_grant ? irender_x : hold_x);
    assign omap_y     = game_grant ? gy : (render_grant ? irender_y : hold_y);
    assign omap_wdata = wdata_q;
    assign ogame_busy = (state != G_IDLE);
    assign ogame_ack  = (state == G_ACK);
    assign ogame_tile = tile_q;
    assign ogame_hit  = hit_q;

    // Address hold and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_x <= '0;
            hold_y <= '0;
            starve <= '0;
        end else begin
            if (game_grant || render_grant) begin
                hold_x <= omap_x;
                hold_y <= omap_y;
            end
            if (game_grant) begin
                starve <= '0;
            end else if (game_port_req && (starve != STARVE_LIM)) begin
                starve <= starve + 1'b1;
            end
        end
    end

    // Render pipeline: grant cycle -> map data cycle -> valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpipe_valid   <= 1'b0;
            rpipe_air     <= 1'b0;
            orender_valid <= 1'b0;
            orender_tile  <= '0;
        end else begin
            rpipe_valid   <= render_grant || (irender_req && !render_in_range);
            rpipe_air     <= !render_in_range;
            orender_valid <= rpipe_valid;
            if (rpipe_valid) begin
                orender_tile <= rpipe_air ? TILE_AIR : imap_rdata;
            end
        end
    end

    // Game operation sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= G_IDLE;
            op_q    <= 2'b00;
            gx      <= '0;
            gy      <= '0;
            wdata_q <= '0;
            tile_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            case (state)
                G_IDLE: begin
                    if (igame_req) begin
                        op_q  <= igame_op;
                        gx    <= igame_x;
                        gy    <= igame_y;
                        state <= G_RD;
                    end
                end
                G_RD: begin
                    if (!game_in_range) begin
                        tile_q <= TILE_AIR;
                        hit_q  <= 1'b0;
                        state  <= G_ACK;
                    end else if (game_grant) begin
                        state <= G_DATA;
                    end
                end
                G_DATA: begin
                    tile_q <= imap_rdata;
                    if ((op_q == OP_COLLECT) && (imap_rdata == TILE_COIN)) begin
                        wdata_q <= TILE_AIR;
                        state   <= G_WR;
                    end else if ((op_q == OP_BUMP) && (imap_rdata == TILE_QUESTION)) begin
                        wdata_q <= TILE_USED;
                        state   <= G_WR;
                    end else begin
                        hit_q <= 1'b0;
                        state <= G_ACK;
                    end
                end
                G_WR: begin
                    if (game_grant) begin
                        hit_q <= 1'b1;
                        state <= G_ACK;
                    end
                end
                G_ACK: begin
                    state <= G_IDLE;
                end
                default: begin
                    state <= G_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
